phase_ctrl: RTL and testbench
=============================

PHASE_CTRL -- requirements
Module: phase_ctrl

Interface
REQ-001 SHALL have parameter ITEM_W, 16, width of the item-memory address counter and item count.
REQ-002 SHALL have parameter TMO_W, 16, width of the watchdog counter.
REQ-003 SHALL have parameter TIMEOUT, 16'd50000, idle-cycle limit in RUN/DRAIN before abort.
REQ-004 SHALL have port clk  input  1  the single clock for all logic.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a job.
REQ-007 SHALL have port abort  input  1  software abort of the current job.
REQ-008 SHALL have port random_num  input  ITEM_W  item-memory entry count, sampled on an accepted start.
REQ-009 SHALL have port get_v  input  1  input-stream beat accepted (valid & ready).
REQ-010 SHALL have port get_fin  input  1  get-side controller reports the last input beat consumed.
REQ-011 SHALL have port dst_valid, dst_ready, dst_last  input  1 each  output-stream handshake observed.
REQ-012 SHALL have port gen  output  1  item-memory generation enable to the core and PRNG.
REQ-013 SHALL have port run  output  1  run enable; get/stream/buffer controllers are held in reset while low.
REQ-014 SHALL have port item_a  output  ITEM_W  item-memory write address.
REQ-015 SHALL have port busy  output  1  high in any state except IDLE.
REQ-016 SHALL have port done  output  1  one-cycle completion pulse.
REQ-017 SHALL have port err  output  1  sticky watchdog/abort flag.
REQ-018 SHALL have port beat_cnt  output  20  count of input beats accepted in the current or last job.
REQ-019 SHALL have port state  output  3  encoded state for status readback.

Function
REQ-020 SHALL implement states IDLE=0, GEN=1, RUN=2, DRAIN=3, DONE=4; codes 5-7 SHALL go to IDLE on the next cycle.
REQ-021 In IDLE, start SHALL latch random_num, clear err and beat_cnt, and enter GEN if random_num!=0, otherwise RUN.
REQ-022 start outside IDLE SHALL be ignored and SHALL NOT affect any register.
REQ-023 gen SHALL be 1 exactly while in GEN; item_a SHALL be 0 on the first GEN cycle, increment by 1 per cycle, and be N-1 on the last GEN cycle (N = latched count).
REQ-024 GEN SHALL last exactly N cycles, then enter RUN; item_a SHALL return to 0 outside GEN.
REQ-025 run SHALL be 1 exactly in RUN and DRAIN.
REQ-026 In RUN, every cycle with get_v=1 SHALL increment beat_cnt by 1; beat_cnt SHALL saturate at 20'hFFFFF.
REQ-027 get_fin=1 in RUN SHALL enter DRAIN on the next cycle; a get_v in the same cycle SHALL still be counted.
REQ-028 In DRAIN, a cycle with dst_valid & dst_ready & dst_last SHALL enter DONE; get_v in DRAIN SHALL NOT count.
REQ-029 DONE SHALL last one cycle with done=1, run=0, then enter IDLE; beat_cnt SHALL hold until the next accepted start.
REQ-030 The watchdog SHALL clear on state entry and on any get_v or dst_valid&dst_ready cycle in RUN/DRAIN, and increment otherwise.
REQ-031 When the watchdog reaches TIMEOUT, the block SHALL set err=1 and enter IDLE on the next cycle without pulsing done.
REQ-032 abort=1 in any non-IDLE state SHALL enter IDLE on the next cycle with err=1 and no done pulse; abort in IDLE SHALL be ignored.
REQ-033 Priority SHALL be rst > abort > watchdog > normal transition.
REQ-034 All outputs SHALL be registered.

Reset
REQ-035 rst=1 SHALL force IDLE, gen=0, run=0, item_a=0, busy=0, done=0, err=0, beat_cnt=0, state=0 and watchdog=0 on the next edge, including mid-job.

Verification
REQ-036 start with random_num=1000 -> gen high exactly 1000 cycles, item_a 0..999, then run=1 on the following cycle.
REQ-037 start with random_num=0 -> GEN skipped; run=1 one cycle after start, gen never high.
REQ-038 RUN with 450 get_v beats, get_fin on the last beat, then dst_last handshake -> beat_cnt=450, one done pulse, state back to 0.
REQ-039 RUN with no traffic, TIMEOUT=100 -> err=1 and IDLE after 100 idle cycles, done never pulses; the next start clears err.
REQ-040 abort in the 5th GEN cycle -> gen=0 and err=1 next cycle; start pulses during GEN and DRAIN -> ignored.
REQ-041 rst asserted in DRAIN -> all outputs at reset values on the next cycle, no done pulse.

Source files
------------

// File: rtl/phase_ctrl.sv
// phase_ctrl: job sequencer for item-memory generation, streaming and drain.
// Tracks input beats and guards RUN/DRAIN with an idle watchdog.
module phase_ctrl #(
    parameter int                ITEM_W  = 16,
    parameter int                TMO_W   = 16,
    parameter logic [TMO_W-1:0]  TIMEOUT = 16'd50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ITEM_W-1:0] random_num,
    input  logic              get_v,
    input  logic              get_fin,
    input  logic              dst_valid,
    input  logic              dst_ready,
    input  logic              dst_last,
    output logic              gen,
    output logic              run,
    output logic [ITEM_W-1:0] item_a,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [19:0]       beat_cnt,
    output logic [2:0]        state
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_GEN   = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [TMO_W-1:0] WDOG_LAST = TIMEOUT - 1'b1;
    localparam logic [19:0]      BEAT_MAX  = 20'hFFFFF;

    logic [2:0]        state_q;
    logic [2:0]        state_d;
    logic [ITEM_W-1:0] count_q;
    logic [TMO_W-1:0]  wdog_q;

    logic dst_hs;
    logic active;
    logic traffic;
    logic wdog_hit;
    logic do_abort;
    logic accept;
    logic gen_last;
    logic set_err;
    logic count_beat;

    assign dst_hs     = dst_valid & dst_ready;
    assign active     = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign traffic    = get_v | dst_hs;
    assign wdog_hit   = active && !traffic && (wdog_q == WDOG_LAST);
    assign do_abort   = abort && (state_q != S_IDLE);
    assign accept     = start && (state_q == S_IDLE);
    assign gen_last   = (item_a == count_q - 1'b1);
    assign count_beat = (state_q == S_RUN) && get_v && !do_abort
                        && (beat_cnt != BEAT_MAX);
    assign state      = state_q;

    // Next-state selection: abort beats watchdog beats normal flow.
    always_comb begin
        state_d = state_q;
        set_err = 1'b0;
        if (do_abort) begin
            state_d = S_IDLE;
            set_err = 1'b1;
        end else if (wdog_hit) begin
            state_d = S_IDLE;
            set_err = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = (random_num != '0) ? S_GEN : S_RUN;
                    end
                end
                S_GEN: begin
                    if (gen_last) state_d = S_RUN;
                end
                S_RUN: begin
                    if (get_fin) state_d = S_DRAIN;
                end
                S_DRAIN: begin
                    if (dst_hs && dst_last) state_d = S_DONE;
                end
                S_DONE: state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State register and per-state enables decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            gen     <= 1'b0;
            run     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            gen     <= (state_d == S_GEN);
            run     <= (state_d == S_RUN) || (state_d == S_DRAIN);
            busy    <= (state_d != S_IDLE);
            done    <= (state_d == S_DONE);
        end
    end

    // Item-memory address walks 0..N-1 across GEN and parks at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            item_a  <= '0;
            count_q <= '0;
        end else begin
            if (accept) count_q <= random_num;
            if (state_q == S_GEN && state_d == S_GEN) begin
                item_a <= item_a + 1'b1;
            end else begin
                item_a <= '0;
            end
        end
    end

    // Sticky error flag, cleared only by an accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (accept) begin
            err <= 1'b0;
        end else if (set_err) begin
            err <= 1'b1;
        end
    end

    // Saturating input-beat counter, held after the job ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
        end else if (accept) begin
            beat_cnt <= '0;
        end else if (count_beat) begin
            beat_cnt <= beat_cnt + 20'd1;
        end
    end

    // Watchdog counts idle RUN/DRAIN cycles; any traffic or state change resets it.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_q <= '0;
        end else if (state_d != state_q || !active || traffic) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_phase_ctrl.sv
// tb_phase_ctrl: scenario bench for phase_ctrl with a reduced watchdog limit.
// Expected item addresses and beat counts are queued at stimulus time.
module tb_phase_ctrl;

    localparam int ITEM_W = 16;
    localparam int TMO   = 100;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              abort;
    logic [ITEM_W-1:0] random_num;
    logic              get_v;
    logic              get_fin;
    logic              dst_valid;
    logic              dst_ready;
    logic              dst_last;
    logic              gen;
    logic              run;
    logic [ITEM_W-1:0] item_a;
    logic              busy;
    logic              done;
    logic              err;
    logic [19:0]       beat_cnt;
    logic [2:0]        state;

    int checks   = 0;
    int failures = 0;

    int unsigned addr_q[$];
    int unsigned beat_q[$];

    phase_ctrl #(
        .ITEM_W  (ITEM_W),
        .TMO_W   (16),
        .TIMEOUT (16'd100)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .random_num (random_num),
        .get_v      (get_v),
        .get_fin    (get_fin),
        .dst_valid  (dst_valid),
        .dst_ready  (dst_ready),
        .dst_last   (dst_last),
        .gen        (gen),
        .run        (run),
        .item_a     (item_a),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .beat_cnt   (beat_cnt),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++;
        if ({gen, run, busy, done, err} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=00000", {gen, run, busy, done, err});
        end
        checks++;
        if (item_a !== '0) begin
            failures++;
            $display("FAIL reset_item_a got=%0d exp=0", item_a);
        end
        checks++;
        if (beat_cnt !== 20'd0) begin
            failures++;
            $display("FAIL reset_beat_cnt got=%0d exp=0", beat_cnt);
        end
        checks++;
        if (state !== 3'd0) begin
            failures++;
            $display("FAIL reset_state got=%0d exp=0", state);
        end
    endtask

    task automatic test_gen_long();
        int gen_cycles;
        int unsigned exp;
        random_num = 16'd1000;
        for (int i = 0; i < 1000; i++) addr_q.push_back(i);
        start = 1'b1;
        step();
        start = 1'b0;
        gen_cycles = 0;
        while (gen === 1'b1 && gen_cycles < 1100) begin
            exp = addr_q.pop_front();
            checks++;
            if (item_a !== exp[ITEM_W-1:0]) begin
                failures++;
                $display("FAIL gen_item_a got=%0d exp=%0d", item_a, exp);
            end
            gen_cycles++;
            start      = (gen_cycles == 10);
            random_num = (gen_cycles == 10) ? 16'd7 : 16'd1000;
            step();
        end
        start = 1'b0;
        checks++;
        if (gen_cycles != 1000) begin
            failures++;
            $display("FAIL gen_length got=%0d exp=1000", gen_cycles);
        end
        checks++;
        if (addr_q.size() != 0) begin
            failures++;
            $display("FAIL gen_addr_left got=%0d exp=0", addr_q.size());
        end
        addr_q.delete();
        checks++;
        if ({run, state} !== {1'b1, 3'd2}) begin
            failures++;
            $display("FAIL gen_to_run got run=%b state=%0d exp run=1 state=2", run, state);
        end
        checks++;
        if (item_a !== '0) begin
            failures++;
            $display("FAIL gen_item_a_park got=%0d exp=0", item_a);
        end
        get_fin = 1'b1;
        step();
        get_fin   = 1'b0;
        dst_valid = 1'b1;
        dst_ready = 1'b1;
        dst_last  = 1'b1;
        step();
        {dst_valid, dst_ready, dst_last} = 3'b000;
        checks++;
        if ({done, run, beat_cnt} !== {1'b1, 1'b0, 20'd0}) begin
            failures++;
            $display("FAIL gen_job_done got done=%b run=%b beats=%0d exp 1 0 0", done, run, beat_cnt);
        end
        step();
        checks++;
        if ({done, state} !== {1'b0, 3'd0}) begin
            failures++;
            $display("FAIL gen_job_idle got done=%b state=%0d exp 0 0", done, state);
        end
    endtask

    task automatic test_stream_450();
        int gen_seen;
        int done_seen;
        int unsigned exp;
        random_num = 16'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({run, gen, state} !== {1'b1, 1'b0, 3'd2}) begin
            failures++;
            $display("FAIL zero_skip got run=%b gen=%b state=%0d exp 1 0 2", run, gen, state);
        end
        beat_q.push_back(450);
        gen_seen = 0;
        for (int i = 0; i < 450; i++) begin
            get_v   = 1'b1;
            get_fin = (i == 449);
            if (gen === 1'b1) gen_seen++;
            step();
        end
        {get_v, get_fin} = 2'b00;
        checks++;
        if (gen_seen != 0) begin
            failures++;
            $display("FAIL zero_gen_seen got=%0d exp=0", gen_seen);
        end
        checks++;
        if ({state, beat_cnt} !== {3'd3, 20'd450}) begin
            failures++;
            $display("FAIL stream_drain got state=%0d beats=%0d exp 3 450", state, beat_cnt);
        end
        get_v      = 1'b1;
        start      = 1'b1;
        random_num = 16'd9;
        step();
        {get_v, start} = 2'b00;
        random_num = 16'd0;
        checks++;
        if ({state, beat_cnt} !== {3'd3, 20'd450}) begin
            failures++;
            $display("FAIL drain_ignore got state=%0d beats=%0d exp 3 450", state, beat_cnt);
        end
        {dst_valid, dst_ready, dst_last} = 3'b110;
        step();
        checks++;
        if (state !== 3'd3) begin
            failures++;
            $display("FAIL drain_not_last got=%0d exp=3", state);
        end
        {dst_valid, dst_ready, dst_last} = 3'b111;
        step();
        {dst_valid, dst_ready, dst_last} = 3'b000;
        done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (done === 1'b1) begin
                done_seen++;
                exp = (beat_q.size() != 0) ? beat_q.pop_front() : 32'hDEAD;
                checks++;
                if (beat_cnt !== exp[19:0]) begin
                    failures++;
                    $display("FAIL stream_beats got=%0d exp=%0d", beat_cnt, exp);
                end
            end
            step();
        end
        checks++;
        if (done_seen != 1) begin
            failures++;
            $display("FAIL stream_done_pulses got=%0d exp=1", done_seen);
        end
        checks++;
        if ({state, busy, beat_cnt} !== {3'd0, 1'b0, 20'd450}) begin
            failures++;
            $display("FAIL stream_hold got state=%0d busy=%b beats=%0d exp 0 0 450", state, busy, beat_cnt);
        end
    endtask

    task automatic test_timeout();
        int cyc;
        int done_seen;
        random_num = 16'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        cyc = 0;
        done_seen = 0;
        while (run === 1'b1 && cyc < 200) begin
            cyc++;
            step();
            if (done === 1'b1) done_seen++;
        end
        checks++;
        if (cyc != TMO) begin
            failures++;
            $display("FAIL tmo_cycles got=%0d exp=%0d", cyc, TMO);
        end
        checks++;
        if ({err, state, done_seen[0]} !== {1'b1, 3'd0, 1'b0}) begin
            failures++;
            $display("FAIL tmo_abort got err=%b state=%0d done=%0d exp 1 0 0", err, state, done_seen);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({err, state} !== {1'b0, 3'd2}) begin
            failures++;
            $display("FAIL tmo_restart got err=%b state=%0d exp 0 2", err, state);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if ({err, state, done} !== {1'b1, 3'd0, 1'b0}) begin
            failures++;
            $display("FAIL run_abort got err=%b state=%0d done=%b exp 1 0 0", err, state, done);
        end
    endtask

    task automatic test_abort_gen();
        random_num = 16'd20;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        checks++;
        if ({gen, item_a} !== {1'b1, 16'd4}) begin
            failures++;
            $display("FAIL abort_pre got gen=%b item_a=%0d exp 1 4", gen, item_a);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if ({gen, err, state, busy, done} !== {1'b0, 1'b1, 3'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL abort_gen got gen=%b err=%b state=%0d busy=%b done=%b exp 0 1 0 0 0",
                     gen, err, state, busy, done);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if ({state, busy, err} !== {3'd0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL abort_idle got state=%0d busy=%b err=%b exp 0 0 1", state, busy, err);
        end
    endtask

    task automatic test_reset_drain();
        random_num = 16'd0;
        start = 1'b1;
        step();
        start   = 1'b0;
        get_v   = 1'b1;
        get_fin = 1'b1;
        step();
        {get_v, get_fin} = 2'b00;
        checks++;
        if ({state, beat_cnt} !== {3'd3, 20'd1}) begin
            failures++;
            $display("FAIL rstd_pre got state=%0d beats=%0d exp 3 1", state, beat_cnt);
        end
        rst = 1'b1;
        {dst_valid, dst_ready, dst_last} = 3'b111;
        step();
        rst = 1'b0;
        {dst_valid, dst_ready, dst_last} = 3'b000;
        checks++;
        if ({gen, run, busy, done, err, item_a, beat_cnt, state} !== '0) begin
            failures++;
            $display("FAIL rst_drain got gen=%b run=%b busy=%b done=%b err=%b a=%0d beats=%0d st=%0d exp all 0",
                     gen, run, busy, done, err, item_a, beat_cnt, state);
        end
        step();
        checks++;
        if ({done, state} !== {1'b0, 3'd0}) begin
            failures++;
            $display("FAIL rst_drain_after got done=%b state=%0d exp 0 0", done, state);
        end
    endtask

    task automatic test_back_to_back();
        int unsigned nums[2]  = '{2, 0};
        int unsigned beats[2] = '{3, 7};
        int unsigned exp;
        int k;
        for (int j = 0; j < 2; j++) begin
            random_num = nums[j][ITEM_W-1:0];
            beat_q.push_back(beats[j]);
            start = 1'b1;
            step();
            start = 1'b0;
            k = 0;
            while (state !== 3'd2 && k < 50) begin
                step();
                k++;
            end
            checks++;
            if (state !== 3'd2) begin
                failures++;
                $display("FAIL b2b_run job=%0d got=%0d exp=2", j, state);
            end
            for (int b = 0; b < int'(beats[j]); b++) begin
                get_v   = 1'b1;
                get_fin = (b == int'(beats[j]) - 1);
                step();
            end
            {get_v, get_fin} = 2'b00;
            {dst_valid, dst_ready, dst_last} = 3'b111;
            step();
            {dst_valid, dst_ready, dst_last} = 3'b000;
            exp = (beat_q.size() != 0) ? beat_q.pop_front() : 32'hDEAD;
            checks++;
            if ({done, beat_cnt} !== {1'b1, exp[19:0]}) begin
                failures++;
                $display("FAIL b2b_done job=%0d got done=%b beats=%0d exp 1 %0d", j, done, beat_cnt, exp);
            end
            step();
        end
        checks++;
        if ({state, done, err} !== {3'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL b2b_end got state=%0d done=%b err=%b exp 0 0 0", state, done, err);
        end
    endtask

    initial begin
        rst        = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        random_num = '0;
        get_v      = 1'b0;
        get_fin    = 1'b0;
        dst_valid  = 1'b0;
        dst_ready  = 1'b0;
        dst_last   = 1'b0;
        test_reset();
        test_gen_long();
        test_stream_450();
        test_timeout();
        test_abort_gen();
        test_reset_drain();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
